link_control: RTL and testbench

Sequencing FSM for the Link character datapath. It paces the datapath to a frame tick and converts debounced button levels into one-cycle move/attack strobes, clamping movement at the 256x176 map edges. It then holds draw_char until the datapath returns draw_done. It sits between the input/debounce logic and the character datapath, and reports completion to the top-level frame scheduler.

---
 rtl/link_control_if.sv | 24 ++
 rtl/link_control.sv | 163 ++++++++++++++++
 tb/tb_link_control.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/link_control_if.sv
// Signal bundle between the Link sequencer (slave side) and the input/datapath logic (master side).
interface link_control_if;
    logic       frame_tick;
    logic       btn_up, btn_down, btn_left, btn_right, btn_attack;
    logic [7:0] link_x, link_y;
    logic       draw_done;
    logic       init, idle, attack;
    logic       move_up, move_down, move_left, move_right;
    logic       draw_char, frame_done, frame_overrun, draw_error;

    modport master (
        output frame_tick, btn_up, btn_down, btn_left, btn_right, btn_attack,
        output link_x, link_y, draw_done,
        input  init, idle, attack, move_up, move_down, move_left, move_right,
        input  draw_char, frame_done, frame_overrun, draw_error
    );

    modport slave (
        input  frame_tick, btn_up, btn_down, btn_left, btn_right, btn_attack,
        input  link_x, link_y, draw_done,
        output init, idle, attack, move_up, move_down, move_left, move_right,
        output draw_char, frame_done, frame_overrun, draw_error
    );
endinterface

// File: rtl/link_control.sv
// Link character sequencer: frame-paced move/attack strobes with map-edge clamping and draw handshake.
// Optional draw watchdog enabled by defining LINK_DRAW_TIMEOUT_EN.
module link_control #(
    parameter int MAP_W         = 256,
    parameter int MAP_H         = 176,
    parameter int SPRITE        = 16,
    parameter int ATTACK_FRAMES = 8,
    parameter int TIMEOUT_CYC   = 1024
) (
    input  logic           clock,
    input  logic           reset,
    link_control_if.slave  lc
);
    localparam logic [8:0] MAX_X    = 9'(MAP_W - SPRITE);
    localparam logic [8:0] MAX_Y    = 9'(MAP_H - SPRITE);
    localparam logic [7:0] ATK_LOAD = 8'(ATTACK_FRAMES - 1);

    // Reject configurations the counters cannot represent.
    if (ATTACK_FRAMES < 1 || ATTACK_FRAMES > 255 || TIMEOUT_CYC < 1) begin : g_bad_param
        $error("link_control: parameter out of range");
    end

    typedef enum logic [2:0] {
        S_RESET, S_INIT, S_WAIT, S_DECIDE, S_ATK, S_MOVE, S_DRAW, S_FIN
    } state_t;

    state_t     state;
    logic [7:0] atk_cnt;
    logic       init_r, idle_r, attack_r, draw_r, done_r, overrun_r;
    logic [3:0] move_r;     // {up, down, left, right}
    logic [3:0] move_sel;
    logic       any_move;

    // Highest-priority pressed direction wins; if it is clamped, nothing moves.
    always_comb begin
        move_sel = 4'b0000;
        if (lc.btn_up)
            move_sel = ({1'b0, lc.link_y} != 9'd0)  ? 4'b1000 : 4'b0000;
        else if (lc.btn_down)
            move_sel = ({1'b0, lc.link_y} <  MAX_Y) ? 4'b0100 : 4'b0000;
        else if (lc.btn_left)
            move_sel = ({1'b0, lc.link_x} != 9'd0)  ? 4'b0010 : 4'b0000;
        else if (lc.btn_right)
            move_sel = ({1'b0, lc.link_x} <  MAX_X) ? 4'b0001 : 4'b0000;
    end

    assign any_move = lc.btn_up | lc.btn_down | lc.btn_left | lc.btn_right;

`ifdef LINK_DRAW_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0] draw_cyc;
    logic          draw_err_r;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_RESET;
            atk_cnt   <= 8'd0;
            init_r    <= 1'b0;
            idle_r    <= 1'b0;
            attack_r  <= 1'b0;
            move_r    <= 4'b0000;
            draw_r    <= 1'b0;
            done_r    <= 1'b0;
            overrun_r <= 1'b0;
`ifdef LINK_DRAW_TIMEOUT_EN
            draw_cyc   <= '0;
            draw_err_r <= 1'b0;
`endif
        end else begin
            // Outputs are registered alongside the state they belong to.
            init_r   <= 1'b0;
            idle_r   <= 1'b0;
            attack_r <= 1'b0;
            move_r   <= 4'b0000;
            draw_r   <= 1'b0;
            done_r   <= 1'b0;

            if (lc.frame_tick && state != S_WAIT)
                overrun_r <= 1'b1;

`ifdef LINK_DRAW_TIMEOUT_EN
            if (state != S_DRAW)
                draw_cyc <= '0;
`endif

            case (state)
                S_RESET: begin
                    state  <= S_INIT;
                    init_r <= 1'b1;
                end
                S_INIT: begin
                    state  <= S_DRAW;
                    draw_r <= 1'b1;
                end
                S_WAIT: begin
                    if (lc.frame_tick) state <= S_DECIDE;
                    else               idle_r <= 1'b1;
                end
                S_DECIDE: begin
                    if (atk_cnt != 8'd0) begin
                        atk_cnt  <= atk_cnt - 8'd1;
                        state    <= S_ATK;
                        attack_r <= 1'b1;
                    end else if (lc.btn_attack) begin
                        atk_cnt  <= ATK_LOAD;
                        state    <= S_ATK;
                        attack_r <= 1'b1;
                    end else if (any_move) begin
                        state  <= S_MOVE;
                        move_r <= move_sel;
                    end else begin
                        state  <= S_DRAW;
                        draw_r <= 1'b1;
                    end
                end
                S_ATK, S_MOVE: begin
                    state  <= S_DRAW;
                    draw_r <= 1'b1;
                end
                S_DRAW: begin
                    if (lc.draw_done) begin
                        state  <= S_FIN;
                        done_r <= 1'b1;
`ifdef LINK_DRAW_TIMEOUT_EN
                    end else if (draw_cyc == TW'(TIMEOUT_CYC - 1)) begin
                        state      <= S_FIN;
                        done_r     <= 1'b1;
                        draw_err_r <= 1'b1;
                    end else begin
                        draw_cyc <= draw_cyc + 1'b1;
                        draw_r   <= 1'b1;
`else
                    end else begin
                        draw_r <= 1'b1;
`endif
                    end
                end
                S_FIN: begin
                    state  <= S_WAIT;
                    idle_r <= 1'b1;
                end
                default: state <= S_RESET;
            endcase
        end
    end

    assign lc.init          = init_r;
    assign lc.idle          = idle_r;
    assign lc.attack        = attack_r;
    assign lc.move_up       = move_r[3];
    assign lc.move_down     = move_r[2];
    assign lc.move_left     = move_r[1];
    assign lc.move_right    = move_r[0];
    assign lc.draw_char     = draw_r;
    assign lc.frame_done    = done_r;
    assign lc.frame_overrun = overrun_r;
`ifdef LINK_DRAW_TIMEOUT_EN
    assign lc.draw_error    = draw_err_r;
`else
    assign lc.draw_error    = 1'b0;
`endif
endmodule

// File: tb/tb_link_control.sv
// Directed bench for link_control: per-cycle expected strobe vectors queued with the stimulus.
module tb_link_control;
    logic clock = 1'b0;
    logic reset;

    link_control_if lc ();

    link_control dut (
        .clock (clock),
        .reset (reset),
        .lc    (lc)
    );

    always #5 clock = ~clock;

    // {init, idle, attack, up, down, left, right, draw_char, frame_done}
    localparam logic [8:0] V_NONE  = 9'h000;
    localparam logic [8:0] V_INIT  = 9'h100;
    localparam logic [8:0] V_IDLE  = 9'h080;
    localparam logic [8:0] V_ATK   = 9'h040;
    localparam logic [8:0] V_MU    = 9'h020;
    localparam logic [8:0] V_MD    = 9'h010;
    localparam logic [8:0] V_ML    = 9'h008;
    localparam logic [8:0] V_MR    = 9'h004;
    localparam logic [8:0] V_DRAW  = 9'h002;
    localparam logic [8:0] V_FDONE = 9'h001;

    // {attack, up, down, left, right}
    localparam logic [4:0] B_NONE = 5'b00000;
    localparam logic [4:0] B_ATK  = 5'b10000;
    localparam logic [4:0] B_UP   = 5'b01000;
    localparam logic [4:0] B_DN   = 5'b00100;
    localparam logic [4:0] B_LT   = 5'b00010;
    localparam logic [4:0] B_RT   = 5'b00001;

    logic [8:0] obs;
    assign obs = {lc.init, lc.idle, lc.attack, lc.move_up, lc.move_down,
                  lc.move_left, lc.move_right, lc.draw_char, lc.frame_done};

    typedef struct {
        logic       tick;
        logic [4:0] btn;
        logic       done;
        logic [8:0] exp;
        string      tag;
    } entry_t;

    entry_t sb[$];
    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_assert++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic push(input logic tick, input logic [4:0] btn, input logic done,
                        input logic [8:0] exp, input string tag);
        entry_t e;
        e.tick = tick;
        e.btn  = btn;
        e.done = done;
        e.exp  = exp;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Each entry: drive at negedge, let one active edge pass, compare at the next negedge.
    task automatic run_queue();
        entry_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            lc.frame_tick = e.tick;
            {lc.btn_attack, lc.btn_up, lc.btn_down, lc.btn_left, lc.btn_right} = e.btn;
            lc.draw_done = e.done;
            @(posedge clock);
            @(negedge clock);
            check(e.tag, 32'(obs), 32'(e.exp));
        end
        lc.frame_tick = 1'b0;
        lc.draw_done  = 1'b0;
    endtask

    task automatic draw_tail(input logic [4:0] btn, input int d, input logic tick_draw,
                             input logic tick_fin, input string tag);
        for (int i = 0; i < d; i++)
            push(tick_draw && (i == 1), btn, 1'b0, V_DRAW, {tag, "/draw"});
        push(1'b0, btn, 1'b1, V_FDONE, {tag, "/fdone"});
        push(tick_fin, btn, 1'b0, V_IDLE, {tag, "/idle"});
    endtask

    task automatic frame(input logic [4:0] btn, input logic has_act, input logic [8:0] act,
                         input int d, input logic tick_draw, input logic tick_fin, input string tag);
        push(1'b1, btn, 1'b0, V_NONE, {tag, "/decide"});
        if (has_act) push(1'b0, btn, 1'b0, act, {tag, "/act"});
        draw_tail(btn, d, tick_draw, tick_fin, tag);
        run_queue();
    endtask

    task automatic init_frame(input int d, input string tag);
        push(1'b0, B_NONE, 1'b0, V_INIT, {tag, "/init"});
        draw_tail(B_NONE, d, 1'b0, 1'b0, tag);
        run_queue();
    endtask

    initial begin
        reset         = 1'b1;
        lc.frame_tick = 1'b0;
        {lc.btn_attack, lc.btn_up, lc.btn_down, lc.btn_left, lc.btn_right} = B_NONE;
        lc.link_x     = 8'd100;
        lc.link_y     = 8'd50;
        lc.draw_done  = 1'b0;

        repeat (3) @(negedge clock);
        check("reset_strobes", 32'(obs), 32'(V_NONE));
        check("reset_overrun", 32'(lc.frame_overrun), 32'd0);
        check("reset_draw_error", 32'(lc.draw_error), 32'd0);

        reset = 1'b0;
        init_frame(5, "boot");
        check("no_overrun_after_boot", 32'(lc.frame_overrun), 32'd0);

        lc.link_x = 8'd100; lc.link_y = 8'd50;
        frame(B_UP | B_RT, 1'b1, V_MU, 3, 1'b0, 1'b0, "up_over_right");

        lc.link_x = 8'd240;
        frame(B_RT, 1'b1, V_NONE, 2, 1'b0, 1'b0, "right_clamp_240");
        lc.link_x = 8'd239;
        frame(B_RT, 1'b1, V_MR, 1, 1'b0, 1'b0, "right_239");

        lc.link_x = 8'd100; lc.link_y = 8'd0;
        frame(B_UP | B_LT, 1'b1, V_NONE, 1, 1'b0, 1'b0, "up_clamp_no_subst");
        lc.link_y = 8'd160;
        frame(B_DN, 1'b1, V_NONE, 1, 1'b0, 1'b0, "down_clamp_160");
        lc.link_x = 8'd0; lc.link_y = 8'd50;
        frame(B_LT, 1'b1, V_NONE, 1, 1'b0, 1'b0, "left_clamp_0");

        frame(B_NONE, 1'b0, V_NONE, 2, 1'b0, 1'b0, "no_button");

        push(1'b0, B_NONE, 1'b1, V_IDLE, "done_in_idle");
        push(1'b0, B_NONE, 1'b0, V_IDLE, "still_idle");
        run_queue();

        lc.link_x = 8'd100;
        frame(B_ATK, 1'b1, V_ATK, 1, 1'b0, 1'b0, "atk_t1");
        for (int t = 2; t <= 8; t++)
            frame(B_LT, 1'b1, V_ATK, 1, 1'b0, 1'b0, $sformatf("atk_t%0d", t));
        for (int t = 9; t <= 10; t++)
            frame(B_LT, 1'b1, V_ML, 1, 1'b0, 1'b0, $sformatf("left_t%0d", t));
        check("no_overrun_before_ovr", 32'(lc.frame_overrun), 32'd0);

        frame(B_NONE, 1'b0, V_NONE, 3, 1'b1, 1'b0, "tick_in_draw");
        check("overrun_set", 32'(lc.frame_overrun), 32'd1);
        lc.link_y = 8'd159;
        frame(B_DN, 1'b1, V_MD, 1, 1'b0, 1'b0, "down_159_after_ovr");
        check("overrun_sticky", 32'(lc.frame_overrun), 32'd1);

        // Abort in the middle of a draw; reset acts without a clock edge.
        push(1'b1, B_NONE, 1'b0, V_NONE, "abort/decide");
        push(1'b0, B_NONE, 1'b0, V_DRAW, "abort/draw");
        push(1'b0, B_NONE, 1'b0, V_DRAW, "abort/draw");
        run_queue();
        #1 reset = 1'b1;
        #1;
        check("async_reset_strobes", 32'(obs), 32'(V_NONE));
        check("async_reset_overrun", 32'(lc.frame_overrun), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        init_frame(2, "reboot");
        check("no_overrun_after_reboot", 32'(lc.frame_overrun), 32'd0);

        frame(B_NONE, 1'b0, V_NONE, 1, 1'b0, 1'b1, "tick_in_fin");
        check("overrun_from_fin", 32'(lc.frame_overrun), 32'd1);

`ifdef LINK_DRAW_TIMEOUT_EN
        push(1'b1, B_NONE, 1'b0, V_NONE, "wd/decide");
        for (int i = 0; i < 1024; i++) push(1'b0, B_NONE, 1'b0, V_DRAW, "wd/draw");
        push(1'b0, B_NONE, 1'b0, V_FDONE, "wd/fdone");
        push(1'b0, B_NONE, 1'b0, V_IDLE, "wd/idle");
        run_queue();
        check("draw_error_set", 32'(lc.draw_error), 32'd1);
`else
        check("draw_error_tied", 32'(lc.draw_error), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
